// File: rtl/alsu_pipe_if.sv
// Operand/control and result bundle for alsu_pipe.
// master drives operands and mode bits, slave returns the registered results.
interface alsu_pipe_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
);
    logic                 in_valid;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 cin;
    logic                 serial_in;
    logic                 direction;
    logic                 red_op_A;
    logic                 red_op_B;
    logic                 bypass_A;
    logic                 bypass_B;
    logic [2:0]           opcode;
    logic [2*WIDTH-1:0]   out;
    logic                 out_valid;
    logic [15:0]          leds;
    logic                 ovf;
    logic [CNT_W-1:0]     err_cnt;

    modport master (
        output in_valid, A, B, cin, serial_in, direction,
        output red_op_A, red_op_B, bypass_A, bypass_B, opcode,
        input  out, out_valid, leds, ovf, err_cnt
    );

    modport slave (
        input  in_valid, A, B, cin, serial_in, direction,
        input  red_op_A, red_op_B, bypass_A, bypass_B, opcode,
        output out, out_valid, leds, ovf, err_cnt
    );
endinterface

// File: rtl/alsu_pipe.sv
// Two-stage handshaked ALSU: stage 1 registers inputs, stage 2 computes.
// SHIFT/ROTATE/MAC feed back from the result register, so ops chain freely.
module alsu_pipe #(
    parameter int WIDTH      = 3,
    parameter     PRIORITY   = "A",
    parameter int FULL_ADDER = 1,
    parameter int CNT_W      = 8
) (
    input logic        clk,
    input logic        rst_n,
    alsu_pipe_if.slave bus
);
    localparam int OUT_W   = 2 * WIDTH;
    localparam bit PRI_B   = (PRIORITY == "B");
    localparam bit USE_CIN = (FULL_ADDER != 0);

    logic             v1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             cin1;
    logic             sin1;
    logic             dir1;
    logic             ra1;
    logic             rb1;
    logic             ba1;
    logic             bb1;
    logic [2:0]       op1;

    logic [OUT_W-1:0] out_q;
    logic             vld_q;
    logic [15:0]      leds_q;
    logic             ovf_q;
    logic [CNT_W-1:0] err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            cin1 <= 1'b0;
            sin1 <= 1'b0;
            dir1 <= 1'b0;
            ra1  <= 1'b0;
            rb1  <= 1'b0;
            ba1  <= 1'b0;
            bb1  <= 1'b0;
            op1  <= '0;
        end else begin
            v1   <= bus.in_valid;
            a1   <= bus.A;
            b1   <= bus.B;
            cin1 <= bus.cin;
            sin1 <= bus.serial_in;
            dir1 <= bus.direction;
            ra1  <= bus.red_op_A;
            rb1  <= bus.red_op_B;
            ba1  <= bus.bypass_A;
            bb1  <= bus.bypass_B;
            op1  <= bus.opcode;
        end
    end

    logic             is_byp;
    logic             is_inv;
    logic             is_red;
    logic             byp_b;
    logic             red_b;
    logic [WIDTH-1:0] red_src;
    logic [OUT_W-1:0] prod;
    logic [OUT_W-1:0] add_res;
    logic [OUT_W:0]   mac_sum;
    logic [OUT_W-1:0] out_d;
    logic             ovf_d;

    // Bypass wins over an otherwise invalid op, so invalid is masked here.
    assign is_byp  = ba1 | bb1;
    assign is_red  = ra1 | rb1;
    assign is_inv  = ~is_byp & ((op1 == 3'd7) | (is_red & (op1 > 3'd1)));
    assign byp_b   = bb1 & (~ba1 | PRI_B);
    assign red_b   = rb1 & (~ra1 | PRI_B);
    assign red_src = red_b ? b1 : a1;
    assign prod    = OUT_W'(a1) * OUT_W'(b1);
    assign add_res = OUT_W'(a1) + OUT_W'(b1) + OUT_W'(cin1 & USE_CIN);
    assign mac_sum = {1'b0, out_q} + {1'b0, prod};

    always_comb begin
        out_d = '0;
        ovf_d = 1'b0;
        unique case (1'b1)
            is_byp:  out_d = byp_b ? OUT_W'(b1) : OUT_W'(a1);
            is_inv:  out_d = '0;
            default: begin
                unique case (op1)
                    3'd0: out_d = is_red ? OUT_W'(|red_src) : OUT_W'(a1 | b1);
                    3'd1: out_d = is_red ? OUT_W'(^red_src) : OUT_W'(a1 ^ b1);
                    3'd2: out_d = add_res;
                    3'd3: out_d = prod;
                    3'd4: out_d = dir1 ? {out_q[OUT_W-2:0], sin1}
                                       : {sin1, out_q[OUT_W-1:1]};
                    3'd5: out_d = dir1 ? {out_q[OUT_W-2:0], out_q[OUT_W-1]}
                                       : {out_q[0], out_q[OUT_W-1:1]};
                    3'd6: begin
                        out_d = mac_sum[OUT_W-1:0];
                        ovf_d = mac_sum[OUT_W];
                    end
                    default: out_d = '0;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            vld_q  <= 1'b0;
            leds_q <= '0;
            ovf_q  <= 1'b0;
            err_q  <= '0;
        end else begin
            vld_q <= v1;
            if (v1) begin
                out_q <= out_d;
                ovf_q <= ovf_d;
                if (is_inv) begin
                    leds_q <= ~leds_q;
                    if (err_q != '1)
                        err_q <= err_q + CNT_W'(1);
                end else begin
                    leds_q <= '0;
                end
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = vld_q;
    assign bus.leds      = leds_q;
    assign bus.ovf       = ovf_q;
    assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_alsu_pipe.sv
// Bench for alsu_pipe: two instances (PRIORITY A/CNT_W 8, PRIORITY B/CNT_W 2)
// share one stimulus stream and are checked against an arithmetic model.
module tb_alsu_pipe;
    localparam int W  = 3;
    localparam int OW = 6;

    typedef struct packed {
        bit v;
        int op;
        int a;
        int b;
        bit cin;
        bit sin;
        bit dir;
        bit ra;
        bit rb;
        bit ba;
        bit bb;
    } op_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         cin = 1'b0;
    logic         serial_in = 1'b0;
    logic         direction = 1'b0;
    logic         red_op_A = 1'b0;
    logic         red_op_B = 1'b0;
    logic         bypass_A = 1'b0;
    logic         bypass_B = 1'b0;
    logic [2:0]   opcode = '0;

    alsu_pipe_if #(.WIDTH(W), .CNT_W(8)) bus_a ();
    alsu_pipe_if #(.WIDTH(W), .CNT_W(2)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.A         = A;
    assign bus_a.B         = B;
    assign bus_a.cin       = cin;
    assign bus_a.serial_in = serial_in;
    assign bus_a.direction = direction;
    assign bus_a.red_op_A  = red_op_A;
    assign bus_a.red_op_B  = red_op_B;
    assign bus_a.bypass_A  = bypass_A;
    assign bus_a.bypass_B  = bypass_B;
    assign bus_a.opcode    = opcode;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.A         = A;
    assign bus_b.B         = B;
    assign bus_b.cin       = cin;
    assign bus_b.serial_in = serial_in;
    assign bus_b.direction = direction;
    assign bus_b.red_op_A  = red_op_A;
    assign bus_b.red_op_B  = red_op_B;
    assign bus_b.bypass_A  = bypass_A;
    assign bus_b.bypass_B  = bypass_B;
    assign bus_b.opcode    = opcode;

    alsu_pipe #(.WIDTH(W), .PRIORITY("A"), .FULL_ADDER(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    alsu_pipe #(.WIDTH(W), .PRIORITY("B"), .FULL_ADDER(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    logic [OW-1:0] o_out  [2];
    logic          o_vld  [2];
    logic [15:0]   o_leds [2];
    logic          o_ovf  [2];
    logic [7:0]    o_err  [2];
    assign o_out[0]  = bus_a.out;
    assign o_out[1]  = bus_b.out;
    assign o_vld[0]  = bus_a.out_valid;
    assign o_vld[1]  = bus_b.out_valid;
    assign o_leds[0] = bus_a.leds;
    assign o_leds[1] = bus_b.leds;
    assign o_ovf[0]  = bus_a.ovf;
    assign o_ovf[1]  = bus_b.ovf;
    assign o_err[0]  = bus_a.err_cnt;
    assign o_err[1]  = {6'b0, bus_b.err_cnt};

    int  n_checks = 0;
    int  n_fail = 0;
    int  m_out [2];
    int  m_leds [2];
    int  m_ovf [2];
    int  m_err [2];
    bit  m_vld;
    op_t pend;

    function automatic op_t mk(int op, int a = 0, int b = 0,
                               bit c = 0, bit s = 0, bit d = 0);
        op_t o;
        o = '0;
        o.v = 1'b1;
        o.op = op;
        o.a = a;
        o.b = b;
        o.cin = c;
        o.sin = s;
        o.dir = d;
        return o;
    endfunction

    function automatic op_t idle();
        op_t o;
        o = '0;
        return o;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            m_out[k] = 0;
            m_leds[k] = 0;
            m_ovf[k] = 0;
            m_err[k] = 0;
        end
        m_vld = 1'b0;
        pend = '0;
    endfunction

    // Result of one op as described by the mode rules, k=1 is the B-priority copy.
    function automatic void model_apply(op_t o);
        int  src;
        int  s;
        bit  sel_b;
        bit  inv;
        m_vld = o.v;
        if (!o.v) return;
        for (int k = 0; k < 2; k++) begin
            m_ovf[k] = 0;
            inv = (o.op == 7) || ((o.ra || o.rb) && o.op > 1);
            if (o.ba || o.bb) begin
                sel_b = o.bb && (!o.ba || k == 1);
                m_out[k] = sel_b ? o.b : o.a;
                m_leds[k] = 0;
            end else if (inv) begin
                m_out[k] = 0;
                m_leds[k] = m_leds[k] ^ 'hFFFF;
                if (m_err[k] < (k == 1 ? 3 : 255)) m_err[k] = m_err[k] + 1;
            end else begin
                m_leds[k] = 0;
                sel_b = o.rb && (!o.ra || k == 1);
                src = sel_b ? o.b : o.a;
                case (o.op)
                    0: m_out[k] = (o.ra || o.rb) ? int'(src != 0) : (o.a | o.b);
                    1: m_out[k] = (o.ra || o.rb) ? ($countones(src) % 2) : (o.a ^ o.b);
                    2: m_out[k] = o.a + o.b + int'(o.cin);
                    3: m_out[k] = o.a * o.b;
                    4: m_out[k] = o.dir ? (m_out[k] * 2) % 64 + int'(o.sin)
                                        : int'(o.sin) * 32 + m_out[k] / 2;
                    5: m_out[k] = o.dir ? (m_out[k] * 2) % 64 + m_out[k] / 32
                                        : (m_out[k] % 2) * 32 + m_out[k] / 2;
                    default: begin
                        s = m_out[k] + o.a * o.b;
                        m_ovf[k] = (s > 63) ? 1 : 0;
                        m_out[k] = s % 64;
                    end
                endcase
            end
        end
    endfunction

    // Present o, clock it in, and advance the model by the op already in stage 1.
    task automatic cycle(op_t o);
        in_valid  = o.v;
        A         = W'(o.a);
        B         = W'(o.b);
        cin       = o.cin;
        serial_in = o.sin;
        direction = o.dir;
        red_op_A  = o.ra;
        red_op_B  = o.rb;
        bypass_A  = o.ba;
        bypass_B  = o.bb;
        opcode    = 3'(o.op);
        @(posedge clk);
        #1;
        model_apply(pend);
        pend = o;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_out[k] !== '0 || o_vld[k] !== 1'b0 || o_leds[k] !== '0
                || o_ovf[k] !== 1'b0 || o_err[k] !== '0) begin
                n_fail++;
                $display("FAIL reset dut%0d: out=%h vld=%b leds=%h ovf=%b err=%0d, want all zero",
                         k, o_out[k], o_vld[k], o_leds[k], o_ovf[k], o_err[k]);
            end
        end
        release_reset();
    endtask

    task automatic test_mul_add();
        cycle(mk(3, 5, 3));
        n_checks++;
        if (o_vld[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_latency: out_valid=%b want 0 one edge after sample", o_vld[0]);
        end
        cycle(mk(2, 7, 7, 1));
        n_checks++;
        if (o_out[0] !== 6'd15 || o_vld[0] !== 1'b1 || o_ovf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_5x3: out=%0d vld=%b ovf=%b want 15 1 0", o_out[0], o_vld[0], o_ovf[0]);
        end
        cycle(idle());
        n_checks++;
        if (o_out[0] !== 6'd15 || o_vld[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL add_7_7_c1: out=%0d vld=%b want 15 1", o_out[0], o_vld[0]);
        end
        cycle(idle());
        n_checks++;
        if (o_out[0] !== 6'd15 || o_vld[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: out=%0d vld=%b want 15 0", o_out[0], o_vld[0]);
        end
    endtask

    task automatic test_mac_chain();
        cycle(mk(3, 5, 6));
        cycle(mk(4, 0, 0, 0, 0, 1));
        cycle(mk(6, 2, 3));
        n_checks++;
        if (o_out[0] !== 6'd60) begin
            n_fail++;
            $display("FAIL mac_setup: out=%0d want 60", o_out[0]);
        end
        cycle(mk(2, 1, 1));
        n_checks++;
        if (o_out[0] !== 6'd2 || o_ovf[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mac_wrap: out=%0d ovf=%b want 2 1", o_out[0], o_ovf[0]);
        end
        cycle(idle());
        n_checks++;
        if (o_out[0] !== 6'd2 || o_ovf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: out=%0d ovf=%b want 2 0", o_out[0], o_ovf[0]);
        end
    endtask

    task automatic test_rot_shift();
        cycle(mk(3, 4, 4));
        cycle(mk(4, 0, 0, 0, 1, 1));
        cycle(mk(5, 0, 0, 0, 0, 1));
        n_checks++;
        if (o_out[0] !== 6'b100001) begin
            n_fail++;
            $display("FAIL shl_setup: out=%b want 100001", o_out[0]);
        end
        cycle(mk(4, 0, 0, 0, 1, 0));
        n_checks++;
        if (o_out[0] !== 6'b000011) begin
            n_fail++;
            $display("FAIL rotl: out=%b want 000011", o_out[0]);
        end
        cycle(idle());
        n_checks++;
        if (o_out[0] !== 6'b100001) begin
            n_fail++;
            $display("FAIL shr_sin1: out=%b want 100001", o_out[0]);
        end
    endtask

    task automatic test_invalid();
        op_t o;
        int  exp_leds;
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        release_reset();
        for (int i = 0; i <= 6; i++) begin
            o = mk(7, 3, 2);
            if (i == 5) begin
                o = mk(2, 1, 1);
                o.ra = 1'b1;
            end
            cycle(i < 6 ? o : idle());
            if (i > 0) begin
                exp_leds = (i % 2 == 1) ? 'hFFFF : 0;
                n_checks++;
                if (o_leds[0] !== 16'(exp_leds) || o_out[0] !== '0
                    || o_err[0] !== 8'(i) || o_vld[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL invalid_a[%0d]: leds=%h out=%0d err=%0d vld=%b want %h 0 %0d 1",
                             i, o_leds[0], o_out[0], o_err[0], o_vld[0], exp_leds, i);
                end
                n_checks++;
                if (o_leds[1] !== 16'(exp_leds) || o_err[1] !== 8'(i > 3 ? 3 : i)) begin
                    n_fail++;
                    $display("FAIL invalid_sat_b[%0d]: leds=%h err=%0d want %h %0d",
                             i, o_leds[1], o_err[1], exp_leds, i > 3 ? 3 : i);
                end
            end
        end
    endtask

    task automatic test_bypass();
        op_t o;
        cycle(mk(7));
        o = mk(7, 1, 6);
        o.ba = 1'b1;
        o.bb = 1'b1;
        cycle(o);
        n_checks++;
        if (o_leds[0] !== 16'hFFFF || o_err[0] !== 8'd7 || o_err[1] !== 8'd3) begin
            n_fail++;
            $display("FAIL pre_bypass: leds=%h err_a=%0d err_b=%0d want ffff 7 3",
                     o_leds[0], o_err[0], o_err[1]);
        end
        cycle(idle());
        n_checks++;
        if (o_out[1] !== 6'd6 || o_leds[1] !== '0 || o_err[1] !== 8'd3) begin
            n_fail++;
            $display("FAIL bypass_prio_b: out=%0d leds=%h err=%0d want 6 0 3",
                     o_out[1], o_leds[1], o_err[1]);
        end
        n_checks++;
        if (o_out[0] !== 6'd1 || o_leds[0] !== '0 || o_err[0] !== 8'd7) begin
            n_fail++;
            $display("FAIL bypass_prio_a: out=%0d leds=%h err=%0d want 1 0 7",
                     o_out[0], o_leds[0], o_err[0]);
        end
        cycle(idle());
        n_checks++;
        if (o_out[1] !== 6'd6 || o_vld[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_hold: out=%0d vld=%b want 6 0", o_out[1], o_vld[1]);
        end
    endtask

    task automatic test_reset_midstream();
        cycle(mk(2, 7, 7, 1));
        cycle(mk(3, 5, 3));
        rst_n = 1'b0;
        model_clear();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_out[k] !== '0 || o_vld[k] !== 1'b0 || o_err[k] !== '0) begin
                n_fail++;
                $display("FAIL midreset dut%0d: out=%0d vld=%b err=%0d want 0 0 0",
                         k, o_out[k], o_vld[k], o_err[k]);
            end
        end
        @(posedge clk);
        release_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(idle());
            n_checks++;
            if (o_vld[0] !== 1'b0 || o_out[0] !== '0) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: vld=%b out=%0d want 0 0", i, o_vld[0], o_out[0]);
            end
        end
    endtask

    task automatic test_random();
        op_t o;
        for (int i = 0; i < 400; i++) begin
            o = mk(int'($urandom_range(7)), int'($urandom_range(7)),
                   int'($urandom_range(7)), 1'($urandom), 1'($urandom), 1'($urandom));
            o.v  = ($urandom_range(4) != 0);
            o.ra = ($urandom_range(3) == 0);
            o.rb = ($urandom_range(3) == 0);
            o.ba = ($urandom_range(7) == 0);
            o.bb = ($urandom_range(7) == 0);
            cycle(o);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_out[k] !== OW'(m_out[k]) || o_vld[k] !== m_vld
                    || o_leds[k] !== 16'(m_leds[k]) || o_ovf[k] !== 1'(m_ovf[k])
                    || o_err[k] !== 8'(m_err[k])) begin
                    n_fail++;
                    $display("FAIL random[%0d] dut%0d: out=%0d vld=%b leds=%h ovf=%b err=%0d want %0d %b %h %0d %0d",
                             i, k, o_out[k], o_vld[k], o_leds[k], o_ovf[k], o_err[k],
                             m_out[k], m_vld, m_leds[k], m_ovf[k], m_err[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_add();
        test_mac_chain();
        test_rot_shift();
        test_invalid();
        test_bypass();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alsu_pipe.md
# alsu_pipe

Parametrised, handshaked successor to the fixed 3-bit ALSU. It has a width-generic datapath, a `in_valid`/`out_valid` two-stage pipeline and a new multiply-accumulate mode. It also adds MAC-overflow and saturating error-count status outputs. It sits between the stimulus/control front end and the LED/display back end, and replaces the 3-bit ALSU wherever a wider operand or a throughput-qualified result is needed.

## Interface
- `WIDTH`, 3: operand width of A and B (≥2). OUT_W = 2*WIDTH.
- `PRIORITY`, "A": bypass winner when `bypass_A` and `bypass_B` are both set ("A" or "B"). Also selects the reduction operand when both `red_op` bits are set.
- `FULL_ADDER`, 1: 1 = add includes `cin`; 0 = `cin` ignored.
- `CNT_W`, 8: width of the error counter.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  qualifies the inputs sampled this cycle.
- `A`, `B`  in  WIDTH  unsigned operands.
- `cin`, `serial_in`, `direction`  in  1 each  carry in; shift fill bit; 1 = left, 0 = right.
- `red_op_A`, `red_op_B`, `bypass_A`, `bypass_B`  in  1 each  mode controls.
- `opcode`  in  3  0 OR, 1 XOR, 2 ADD, 3 MUL, 4 SHIFT, 5 ROTATE, 6 MAC, 7 invalid.
- `out`  out  OUT_W  result register.
- `out_valid`  out  1  `out` updated by an op this cycle.
- `leds`  out  16  error blink register.
- `ovf`  out  1  last op was a MAC that wrapped.
- `err_cnt`  out  CNT_W  saturating count of invalid ops.

## Operation
- Stage 1 captures all inputs every cycle. `v1 <= in_valid`.
- Stage 2 acts only when `v1` = 1. All stage-2 operands are stage-1 registered values. When `v1` = 0, `out`, `leds`, `ovf` and `err_cnt` hold and `out_valid` = 0.
- Invalid op: opcode = 7, or (`red_op_A` | `red_op_B`) with opcode ∉ {0, 1}. An invalid op is overridden by an active bypass.
- Decode priority: bypass > invalid > opcode.
- Bypass: `out` = zero-extended A (or B), resolved per `PRIORITY`.
- Invalid: `out` = 0, `leds` <= ~`leds`, `err_cnt` += 1, saturating at 2^CNT_W−1.
- Any valid op, including bypass: `leds` <= 0.
- OR / XOR:
  - With a `red_op` bit set: 1-bit reduction of the selected operand (A when `red_op_A`; both bits set → per `PRIORITY`), zero-extended.
  - Otherwise: bitwise A op B, zero-extended.
- ADD: A + B + (`FULL_ADDER` ? `cin` : 0), zero-extended. This never overflows OUT_W.
- MUL: full unsigned product A*B.
- SHIFT, using the current `out`:
  - left: {`out`[OUT_W−2:0], `serial_in`}
  - right: {`serial_in`, `out`[OUT_W−1:1]}
- ROTATE, using the current `out`:
  - left: {`out`[OUT_W−2:0], `out`[OUT_W−1]}
  - right: {`out`[0], `out`[OUT_W−1:1]}
- MAC: `out` <= (`out` + A*B) mod 2^OUT_W. `ovf` = carry out of that sum.
- `ovf` is rewritten on every stage-2 op and is 0 for every non-MAC op.
- `direction` is sampled only for SHIFT and ROTATE. `cin` is sampled only for ADD.

## Timing
- Latency: inputs sampled at edge N with `in_valid` = 1 → `out`/`leds`/`ovf`/`err_cnt` updated at edge N+1 → `out_valid` = 1 after edge N+1 for one cycle per op.
- Throughput: one op per cycle. Back-to-back valids produce back-to-back results.
- SHIFT, ROTATE and MAC read `out` as left by the previous op, so consecutive ops chain with no bubble.
- There is no backpressure. A consumer that misses `out_valid` loses the result.
- Reset (asynchronous, any time, including mid-pipeline):
  - `out` = 0, `leds` = 0, `ovf` = 0, `err_cnt` = 0, `out_valid` = 0, `v1` = 0.
  - All stage-1 registers clear.
- First-op timing: the first op sampled on the edge after reset release produces a result on the following edge.
- `leds` toggles once per invalid op. Consecutive invalid ops alternate FFFF/0000.

## Test plan
- Reset mid-stream: drive MUL A=5, B=3, then assert `rst_n` = 0 between the two edges → `out` = 0, `out_valid` = 0 immediately, with no result after release.
- MUL, WIDTH=3: A=5, B=3, `in_valid` = 1 → two edges later `out` = 15, `out_valid` = 1, `ovf` = 0. ADD with A=7, B=7, `cin` = 1 → `out` = 15.
- MAC chain, WIDTH=3:
  - `out` = 60, MAC A=2, B=3 → `out` = 2, `ovf` = 1.
  - Next op ADD 1+1 → `ovf` = 0.
- Rotate/shift, WIDTH=3:
  - `out` = 6'b100001, ROTATE left → 6'b000011.
  - Then SHIFT right with `serial_in` = 1 → 6'b100001.
- Invalid handling:
  - opcode 7, three times → `leds` FFFF, 0000, FFFF; `out` = 0; `err_cnt` = 3.
  - `red_op_A` = 1 with opcode 2 → counted as invalid.
  - With `CNT_W` = 2, five invalid ops → `err_cnt` saturates at 3.
- Bypass priority:
  - `PRIORITY` = "B", `bypass_A` = `bypass_B` = 1, A=1, B=6, opcode 7 → `out` = 6, `leds` = 0, `err_cnt` unchanged.
  - `in_valid` = 0 → `out` holds, `out_valid` = 0.
